// File: rtl/npu_launch_seq_if.sv
// AXI4-Lite bus bundle between the NPU launch sequencer (master) and the
// NPU control/status register bank (slave).
//
// Signals (named from the master's point of view):
//   awaddr/awvalid/awready        write-address channel
//   wdata/wstrb/wvalid/wready     write-data channel
//   bresp/bvalid/bready           write-response channel
//   araddr/arvalid/arready        read-address channel
//   rdata/rresp/rvalid/rready     read-data channel
// Modports: master (sequencer side) and slave (register bank side).
interface npu_launch_seq_if #(
  parameter int LITE_ADDR_W = 32,
  parameter int LITE_DATA_W = 32,
  parameter int LITE_STRB_W = 4
);
  logic [LITE_ADDR_W-1:0] awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [LITE_DATA_W-1:0] wdata;
  logic [LITE_STRB_W-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [LITE_ADDR_W-1:0] araddr;
  logic                   arvalid;
  logic                   arready;
  logic [LITE_DATA_W-1:0] rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/npu_launch_seq.sv
// NPU job launch sequencer. Accepts one job descriptor, programs the NPU
// register bank over AXI4-Lite (UCODE_BASE, UCODE_LEN, SEQ_LEN, TOKEN_IDX,
// then CTRL.START), polls STATUS until done/error/timeout and hands back a
// completion record. One job in flight at a time.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   job_valid/job_ready  job descriptor handshake
//   job_ucode_base, job_ucode_len, job_seq_len, job_token_idx  descriptor fields
//   m_axil               AXI4-Lite master bus (npu_launch_seq_if.master)
//   cmpl_valid/cmpl_ready completion handshake
//   cmpl_status          0=OK 1=NPU error 2=AXI error 3=timeout
//   cmpl_polls           STATUS reads issued for this job (saturating)
//   busy_o               high whenever the sequencer is not idle
module npu_launch_seq #(
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int          LITE_ADDR_W = 32,
  parameter int          LITE_DATA_W = 32,
  parameter int          LITE_STRB_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [31:0]            job_ucode_base,
  input  logic [31:0]            job_ucode_len,
  input  logic [31:0]            job_seq_len,
  input  logic [31:0]            job_token_idx,
  npu_launch_seq_if.master       m_axil,
  output logic                   cmpl_valid,
  input  logic                   cmpl_ready,
  output logic [1:0]             cmpl_status,
  output logic [15:0]            cmpl_polls,
  output logic                   busy_o
);

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  ST_OK          = 2'd0;
  localparam logic [1:0]  ST_NPU_ERR     = 2'd1;
  localparam logic [1:0]  ST_AXI_ERR     = 2'd2;
  localparam logic [1:0]  ST_TIMEOUT     = 2'd3;
  localparam int          CTRL_START     = 0;
  localparam logic [7:0]  REG_CTRL       = 8'h00;
  localparam logic [7:0]  REG_STATUS     = 8'h04;
  localparam logic [7:0]  REG_UCODE_BASE = 8'h08;
  localparam logic [7:0]  REG_UCODE_LEN  = 8'h0C;
  localparam logic [7:0]  REG_SEQ_LEN    = 8'h2C;
  localparam logic [7:0]  REG_TOKEN_IDX  = 8'h30;
  localparam logic [15:0] GAP_INIT       = 16'(POLL_GAP);
  localparam logic [31:0] TMO_LIMIT      = 32'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_POLL_WAIT, S_RD_REQ, S_RD_RESP, S_CMPL
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wr_idx_q;
  logic [31:0] base_q, len_q, seq_q, tok_q;
  logic        aw_done_q, w_done_q;
  logic [15:0] gap_q;
  logic [31:0] tmo_q;
  logic [15:0] polls_q;
  logic [1:0]  status_q, status_d;
  logic        out_of_reset_q;
  logic        reload_gap;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        aw_hs, w_hs, wr_accept, tmo_expired, polling;
  logic        unused_rdata;

  // Only the done and error bits of STATUS matter to the sequencer.
  assign unused_rdata = ^{m_axil.rdata[LITE_DATA_W-1:3], m_axil.rdata[1]};

  assign aw_hs       = (state_q == S_WR_REQ) && !aw_done_q && m_axil.awready;
  assign w_hs        = (state_q == S_WR_REQ) && !w_done_q && m_axil.wready;
  assign wr_accept   = (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign tmo_expired = (tmo_q >= TMO_LIMIT);
  assign polling     = (state_q == S_POLL_WAIT) || (state_q == S_RD_REQ) ||
                       (state_q == S_RD_RESP);
  assign cmpl_status = status_q;
  assign cmpl_polls  = polls_q;
  assign busy_o      = (state_q != S_IDLE);

  // Register write sequence: address/data chosen by the write index.
  always_comb begin
    wr_addr = REG_CTRL;
    wr_data = 32'h1 << CTRL_START;
    case (wr_idx_q)
      3'd0: begin wr_addr = REG_UCODE_BASE; wr_data = base_q; end
      3'd1: begin wr_addr = REG_UCODE_LEN;  wr_data = len_q;  end
      3'd2: begin wr_addr = REG_SEQ_LEN;    wr_data = seq_q;  end
      3'd3: begin wr_addr = REG_TOKEN_IDX;  wr_data = tok_q;  end
      default: ;
    endcase
  end

  // State register; also holds job_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_of_reset_q <= 1'b1;
    end
  end

  // Next-state and bus outputs. Timeout never abandons an issued AR; a
  // returning R beat is always decoded before the timeout is honoured.
  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    reload_gap     = 1'b0;
    job_ready      = 1'b0;
    cmpl_valid     = 1'b0;
    m_axil.awvalid = 1'b0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    m_axil.awaddr  = LITE_ADDR_W'(wr_addr);
    m_axil.wdata   = LITE_DATA_W'(wr_data);
    m_axil.wstrb   = '1;
    m_axil.araddr  = LITE_ADDR_W'(REG_STATUS);
    case (state_q)
      S_IDLE: begin
        job_ready = out_of_reset_q;
        if (job_valid && out_of_reset_q) state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        m_axil.awvalid = !aw_done_q;
        m_axil.wvalid  = !w_done_q;
        if (wr_accept) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_axil.bready = 1'b1;
        if (m_axil.bvalid) begin
          if (m_axil.bresp != RESP_OKAY) begin
            status_d = ST_AXI_ERR;
            state_d  = S_CMPL;
          end else if (wr_idx_q < 3'd4) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_POLL_WAIT;
          end
        end
      end
      S_POLL_WAIT: begin
        if (tmo_expired) begin
          status_d = ST_TIMEOUT;
          state_d  = S_CMPL;
        end else if (gap_q <= 16'd1) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        m_axil.arvalid = 1'b1;
        if (m_axil.arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        m_axil.rready = 1'b1;
        if (m_axil.rvalid) begin
          state_d = S_CMPL;
          if (m_axil.rresp != RESP_OKAY)  status_d = ST_AXI_ERR;
          else if (m_axil.rdata[2])       status_d = ST_NPU_ERR;
          else if (m_axil.rdata[0])       status_d = ST_OK;
          else if (tmo_expired)           status_d = ST_TIMEOUT;
          else begin
            state_d    = S_POLL_WAIT;
            reload_gap = 1'b1;
          end
        end
      end
      S_CMPL: begin
        cmpl_valid = 1'b1;
        if (cmpl_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job fields, write progress, poll gap, timeout and completion record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= 3'd0;
      base_q    <= '0;
      len_q     <= '0;
      seq_q     <= '0;
      tok_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      gap_q     <= '0;
      tmo_q     <= '0;
      polls_q   <= '0;
      status_q  <= ST_OK;
    end else begin
      status_q <= status_d;
      if (polling && !tmo_expired) tmo_q <= tmo_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (job_valid && out_of_reset_q) begin
            base_q    <= job_ucode_base;
            len_q     <= job_ucode_len;
            seq_q     <= job_seq_len;
            tok_q     <= job_token_idx;
            wr_idx_q  <= 3'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            polls_q   <= '0;
          end
        end
        S_WR_REQ: begin
          if (wr_accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (m_axil.bvalid && m_axil.bresp == RESP_OKAY) begin
            if (wr_idx_q < 3'd4) begin
              wr_idx_q <= wr_idx_q + 3'd1;
            end else begin
              tmo_q   <= '0;
              polls_q <= '0;
              gap_q   <= GAP_INIT;
            end
          end
        end
        S_POLL_WAIT: if (gap_q != 16'd0) gap_q <= gap_q - 16'd1;
        S_RD_REQ: begin
          if (m_axil.arready && polls_q != 16'hFFFF) polls_q <= polls_q + 16'd1;
        end
        S_RD_RESP: if (reload_gap) gap_q <= GAP_INIT;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_launch_seq.sv
// Directed self-checking bench for npu_launch_seq with a small reactive
// AXI4-Lite register-bank model (configurable AW stall, B error injection,
// scripted STATUS values) and a write log.
module tb_npu_launch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_ucode_base = '0;
  logic [31:0] job_ucode_len = '0;
  logic [31:0] job_seq_len = '0;
  logic [31:0] job_token_idx = '0;
  logic        cmpl_valid;
  logic        cmpl_ready = 1'b0;
  logic [1:0]  cmpl_status;
  logic [15:0] cmpl_polls;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Register-bank model configuration, written only by the stimulus block.
  int          aw_stall_cfg = 0;
  int          err_idx_cfg = 99;
  int          sts_poll_cfg = 1;
  logic [31:0] sts_word_cfg = 32'h1;

  // Register-bank model state.
  logic [3:0]  aw_wait_cnt;
  logic        have_aw, have_w;
  logic [31:0] aw_addr_r, w_data_r;
  int          wr_cnt, rd_cnt;
  logic [31:0] wr_addr_log [0:7];
  logic [31:0] wr_data_log [0:7];
  logic [31:0] last_araddr;
  int unsigned ctrl_b_cyc;

  npu_launch_seq_if bus ();

  npu_launch_seq #(.POLL_GAP(4), .TIMEOUT_CYC(100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_ucode_base (job_ucode_base),
    .job_ucode_len  (job_ucode_len),
    .job_seq_len    (job_seq_len),
    .job_token_idx  (job_token_idx),
    .m_axil         (bus),
    .cmpl_valid     (cmpl_valid),
    .cmpl_ready     (cmpl_ready),
    .cmpl_status    (cmpl_status),
    .cmpl_polls     (cmpl_polls),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.awready = (aw_wait_cnt == 4'd0);
  assign bus.wready  = 1'b1;
  assign bus.arready = 1'b1;
  assign bus.rresp   = 2'b00;

  // Register-bank model: logs completed writes, answers B and R channels.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait_cnt <= 4'd0;
      have_aw     <= 1'b0;
      have_w      <= 1'b0;
      aw_addr_r   <= '0;
      w_data_r    <= '0;
      wr_cnt      <= 0;
      rd_cnt      <= 0;
      last_araddr <= '0;
      ctrl_b_cyc  <= 0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'b00;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      if (job_valid && job_ready) begin
        wr_cnt      <= 0;
        rd_cnt      <= 0;
        aw_wait_cnt <= 4'(aw_stall_cfg);
      end
      if (bus.awvalid && !bus.awready) aw_wait_cnt <= aw_wait_cnt - 4'd1;
      if (bus.awvalid && bus.awready) begin
        aw_addr_r   <= bus.awaddr;
        have_aw     <= 1'b1;
        aw_wait_cnt <= 4'(aw_stall_cfg);
      end
      if (bus.wvalid && bus.wready) begin
        w_data_r <= bus.wdata;
        have_w   <= 1'b1;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
        if (wr_cnt == 5) ctrl_b_cyc <= cyc;
      end else if (!bus.bvalid && (have_aw || (bus.awvalid && bus.awready)) &&
                   (have_w || (bus.wvalid && bus.wready))) begin
        if (wr_cnt < 8) begin
          wr_addr_log[wr_cnt] <= (bus.awvalid && bus.awready) ? bus.awaddr : aw_addr_r;
          wr_data_log[wr_cnt] <= (bus.wvalid && bus.wready) ? bus.wdata : w_data_r;
        end
        bus.bvalid <= 1'b1;
        bus.bresp  <= (wr_cnt == err_idx_cfg) ? 2'b10 : 2'b00;
        have_aw    <= 1'b0;
        have_w     <= 1'b0;
        wr_cnt     <= wr_cnt + 1;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid  <= 1'b1;
        bus.rdata   <= (rd_cnt + 1 >= sts_poll_cfg) ? sts_word_cfg : 32'h2;
        last_araddr <= bus.araddr;
        rd_cnt      <= rd_cnt + 1;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one job descriptor and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] l,
                               input logic [31:0] s, input logic [31:0] t);
    int n = 0;
    @(negedge clk);
    job_ucode_base = b;
    job_ucode_len  = l;
    job_seq_len    = s;
    job_token_idx  = t;
    job_valid      = 1'b1;
    while (!job_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("job_accept", {31'd0, job_ready}, 32'd1);
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  // Waits (bounded) for completion, checks the record, holds it, then accepts.
  task automatic waitCmpl(input string tag, input logic [1:0] exp_st, input int exp_pl,
                          output int unsigned at_cyc);
    int n = 0;
    while (!cmpl_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    checkOutput({tag, "_valid"}, {31'd0, cmpl_valid}, 32'd1);
    checkOutput({tag, "_status"}, {30'd0, cmpl_status}, {30'd0, exp_st});
    if (exp_pl >= 0) checkOutput({tag, "_polls"}, {16'd0, cmpl_polls}, 32'(exp_pl));
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_hold"}, {29'd0, cmpl_valid, cmpl_status}, {29'd0, 1'b1, exp_st});
    cmpl_ready = 1'b1;
    @(posedge clk);
    #1 cmpl_ready = 1'b0;
    checkOutput({tag, "_idle"}, {29'd0, cmpl_valid, busy_o, job_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_a [0:4];
    logic [31:0] exp_d [0:4];
    int unsigned t_done;
    int aw_n, w_n;

    // Reset state.
    #12;
    checkOutput("reset_outputs",
                {24'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                 bus.rready, busy_o, job_ready, cmpl_valid}, 32'd0);
    checkOutput("reset_cmpl", {14'd0, cmpl_status, cmpl_polls}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_job_ready", {31'd0, job_ready}, 32'd1);

    // Job 1: zero-wait slave, done on the third poll.
    $display("[TB] job 1: nominal launch");
    sts_poll_cfg = 3;
    sts_word_cfg = 32'h1;
    applyStimulus(32'h1000, 32'h40, 32'd8, 32'd3);
    waitCmpl("t1", 2'd0, 3, t_done);
    exp_a = '{32'h08, 32'h0C, 32'h2C, 32'h30, 32'h00};
    exp_d = '{32'h1000, 32'h40, 32'd8, 32'd3, 32'h1};
    checkOutput("t1_wr_count", 32'(wr_cnt), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t1_wr%0d_addr", i), wr_addr_log[i], exp_a[i]);
      checkOutput($sformatf("t1_wr%0d_data", i), wr_data_log[i], exp_d[i]);
    end
    checkOutput("t1_araddr", last_araddr, 32'h04);

    // Job 2: AW stalled 5 cycles, W immediately ready.
    $display("[TB] job 2: awready stall");
    aw_stall_cfg = 5;
    sts_poll_cfg = 1;
    applyStimulus(32'hA0, 32'h11, 32'h22, 32'h33);
    aw_n = 0;
    w_n  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.wvalid) w_n++;
      if (bus.awvalid) aw_n++;
      else if (aw_n > 0) break;
    end
    checkOutput("t2_awvalid_cycles", 32'(aw_n), 32'd6);
    checkOutput("t2_wvalid_cycles", 32'(w_n), 32'd1);
    waitCmpl("t2", 2'd0, 1, t_done);
    checkOutput("t2_wr0_addr", wr_addr_log[0], 32'h08);
    checkOutput("t2_wr0_data", wr_data_log[0], 32'hA0);
    checkOutput("t2_wr3_data", wr_data_log[3], 32'h33);
    checkOutput("t2_wr_count", 32'(wr_cnt), 32'd5);
    aw_stall_cfg = 0;

    // Job 3: SLVERR on the UCODE_LEN write.
    $display("[TB] job 3: write response error");
    err_idx_cfg = 1;
    applyStimulus(32'h2000, 32'h80, 32'd4, 32'd1);
    waitCmpl("t3", 2'd2, 0, t_done);
    checkOutput("t3_wr_count", 32'(wr_cnt), 32'd2);
    checkOutput("t3_rd_count", 32'(rd_cnt), 32'd0);
    err_idx_cfg = 99;

    // Job 4: busy+error on the second poll.
    $display("[TB] job 4: NPU error status");
    sts_poll_cfg = 2;
    sts_word_cfg = 32'h6;
    applyStimulus(32'h3000, 32'h10, 32'd2, 32'd0);
    waitCmpl("t4", 2'd1, 2, t_done);

    // Job 5: STATUS stuck busy -> timeout after 100 polling cycles.
    $display("[TB] job 5: timeout");
    sts_poll_cfg = 32'hFFFF;
    sts_word_cfg = 32'h2;
    applyStimulus(32'h4000, 32'h20, 32'd1, 32'd7);
    waitCmpl("t5", 2'd3, -1, t_done);
    checkOutput("t5_latency_window",
                {31'd0, (t_done - ctrl_b_cyc >= 100) && (t_done - ctrl_b_cyc <= 112)}, 32'd1);

    // Job 6: reset during WR_RESP, then a clean job.
    $display("[TB] job 6: reset mid-transaction");
    sts_poll_cfg = 1;
    sts_word_cfg = 32'h1;
    applyStimulus(32'h5000, 32'h30, 32'd6, 32'd2);
    for (int i = 0; i < 50; i++) begin
      if (bus.bready) break;
      @(negedge clk);
    end
    checkOutput("t6_in_wr_resp", {31'd0, bus.bready}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset",
                {24'd0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                 bus.rready, busy_o, job_ready, cmpl_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_ready_at_release", {31'd0, job_ready}, 32'd0);
    @(negedge clk);
    checkOutput("t6_ready_after_release", {31'd0, job_ready}, 32'd1);
    applyStimulus(32'h6000, 32'h44, 32'd9, 32'd5);
    waitCmpl("t6", 2'd0, 1, t_done);
    checkOutput("t6_wr_count", 32'(wr_cnt), 32'd5);
    checkOutput("t6_wr4_data", wr_data_log[4], 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
